uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Round-robin arbiter and sequencer sharing the single `uart_tx_module` transmitter among `NUM_REQ` byte producers. Each requester presents a byte with a valid/ready handshake. The arbiter picks one requester, issues a one-cycle start pulse to the transmitter, and holds the byte stable until the transmitter's busy flag falls. It reports the serving requester, completion, a protocol timeout, and a running byte count. It sits between the system's message sources and the `io_interface` UART TX path.

## Interface
- `NUM_REQ`, default 4: number of requesters; legal range 2..8.
- `BUSY_TIMEOUT`, default 4: cycles in WAIT_BUSY without `uart_busy` before abort; legal range 1..15.
- `IDW`: localparam, `$clog2(NUM_REQ)`.

Ports:
- `clk`: input, 1. Single clock, rising edge.
- `rst`: input, 1. Asynchronous, active-high reset.
- `req_valid`: input, NUM_REQ. Bit i: requester i has a byte.
- `req_data`: input, 8*NUM_REQ. Byte i at `[8*i+7:8*i]`.
- `req_ready`: output, NUM_REQ. One-hot acceptance strobe.
- `uart_start`: output, 1. One-cycle start pulse to the transmitter.
- `uart_data`: output, 8. Byte to the transmitter; stable from START until return to IDLE.
- `uart_busy`: input, 1. Transmitter busy flag.
- `grant_id`: output, IDW. Index of the last accepted requester.
- `active`: output, 1. High in any state except IDLE.
- `done`: output, 1. One-cycle pulse when a byte completes (busy falls).
- `timeout_err`: output, 1. One-cycle pulse on busy-timeout abort.
- `bytes_sent`: output, 16. Count of completed bytes; wraps 0xFFFF→0.

## Operation
- FSM states: IDLE, START, WAIT_BUSY, WAIT_DONE.
- **IDLE**
  - If `uart_busy`=0 and any `req_valid` is set, the winner is the first set bit searching upward (modulo NUM_REQ) from `last_grant+1`.
  - `req_ready[winner]` is asserted combinationally in that cycle; all other bits are 0.
  - At the rising edge: latch `req_data[winner]` into `uart_data`, set `grant_id`/`last_grant` to winner, go to START.
  - If `uart_busy`=1 in IDLE, nothing is accepted.
- **START**: `uart_start`=1 (registered); go to WAIT_BUSY.
- **WAIT_BUSY**
  - If `uart_busy`=1, go to WAIT_DONE.
  - Otherwise increment the timeout counter. When it reaches `BUSY_TIMEOUT`, pulse `timeout_err`, do not count the byte, and go to IDLE.
  - An aborted byte is dropped, not retried.
- **WAIT_DONE**: when `uart_busy`=0, pulse `done`, increment `bytes_sent`, and go to IDLE.
- Requester rules:
  - A requester holds `req_valid` and its data until it sees `req_ready` at an edge. Transfer occurs at that edge.
  - Dropping `req_valid` before acceptance is allowed and simply withdraws the request.
- Fairness: a requester that stays valid is served within NUM_REQ grants.
- `last_grant` resets to NUM_REQ-1, so requester 0 has first priority after reset.

## Timing
- Reset values:
  - State IDLE, `last_grant`=NUM_REQ-1.
  - `uart_start`=0, `uart_data`=0x00, `grant_id`=0, `active`=0, `done`=0, `timeout_err`=0, `bytes_sent`=0.
  - `req_ready` is forced to 0 while `rst`=1.
- Accept edge = cycle 0. Then:
  - `uart_start`=1 during cycle 1.
  - WAIT_BUSY from cycle 2.
  - `done` high in the cycle IDLE is re-entered, after the edge where `uart_busy`=0 is sampled in WAIT_DONE.
- Throughput: the earliest next acceptance is the cycle IDLE is re-entered, provided `uart_busy`=0.
- `done` and `timeout_err` are registered and never high together.
- Simultaneous valids: exactly one `req_ready` bit per acceptance.
- `req_valid` changes outside IDLE are ignored.
- `rst` asserted mid-transfer: immediately return to IDLE with all outputs at reset values. The in-flight byte is lost and not counted. Unaccepted requests are re-arbitrated after release.
- `bytes_sent` wraps silently.

## Test plan
- **Single request:** reset; `req_valid`=0001, byte0=0xA5; model busy rising 1 cycle after start and lasting 10 cycles. Required: `req_ready`=0001 for one cycle; `uart_start` one cycle later with `uart_data`=0xA5; `done` pulses once; `bytes_sent`=1; `grant_id`=0.
- **Round-robin:** all four valid continuously with bytes 0x10, 0x11, 0x12, 0x13. Required: grant order 0,1,2,3,0,1; serial bytes 0x10,0x11,0x12,0x13,0x10,0x11; `bytes_sent`=6.
- **Pointer wrap and skip:** after a grant to 2, only bits 0 and 1 are valid. Required: next grant is 0, then 1.
- **Busy never rises:** the transmitter model ignores start. Required: `timeout_err` pulses exactly BUSY_TIMEOUT cycles after leaving START (4 by default); `bytes_sent` unchanged; return to IDLE; the next request is accepted normally.
- **Busy held in IDLE:** `uart_busy` is forced to 1 with `req_valid`=0010. Required: no `req_ready` while busy; accepted on the first cycle after busy drops.
- **Reset mid-transfer:** `rst` pulses during WAIT_DONE. Required: all outputs return to reset values the same cycle; `bytes_sent`=0; requester 0 has priority after release.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter among NUM_REQ byte producers.
// Accepts one byte per transfer, pulses start, then tracks the transmitter busy flag to completion or timeout.
module uart_tx_arbiter #(
    parameter int  NUM_REQ      = 4,
    parameter int  BUSY_TIMEOUT = 4,
    localparam int IDW          = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 uart_start,
    output logic [7:0]           uart_data,
    input  logic                 uart_busy,
    output logic [IDW-1:0]       grant_id,
    output logic                 active,
    output logic                 done,
    output logic                 timeout_err,
    output logic [15:0]          bytes_sent
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT_BUSY,
        S_WAIT_DONE
    } state_t;

    state_t         state;
    state_t         state_d;
    logic [IDW-1:0] last_grant;
    logic [3:0]     tmo_cnt;

    logic           pick_valid;
    logic [IDW-1:0] pick_idx;
    logic [IDW-1:0] cand;
    logic [7:0]     pick_byte;
    logic           accept;
    logic           byte_done;
    logic           tmo_fire;

    // Search upward from the requester after the last winner, wrapping modulo NUM_REQ.
    // NOTE: every variable written here gets a default before the loop so no latch is inferred.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            cand = IDW'((int'(last_grant) + off) % NUM_REQ);
            if (!pick_valid && req_valid[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    assign pick_byte = req_data[{pick_idx, 3'b000} +: 8];

    // Acceptance needs an idle transmitter; reset masks the strobe so nothing transfers while held.
    assign accept    = (state == S_IDLE) && !uart_busy && pick_valid && !rst;
    assign req_ready = accept ? (NUM_REQ'(1) << pick_idx) : '0;
    assign active    = (state != S_IDLE);

    always_comb begin
        state_d   = state;
        byte_done = 1'b0;
        tmo_fire  = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                state_d = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (uart_busy) begin
                    state_d = S_WAIT_DONE;
                end else if (tmo_cnt == 4'(BUSY_TIMEOUT - 1)) begin
                    tmo_fire = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            S_WAIT_DONE: begin
                if (!uart_busy) begin
                    byte_done = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            last_grant  <= IDW'(NUM_REQ - 1);
            grant_id    <= '0;
            uart_data   <= 8'h00;
            uart_start  <= 1'b0;
            tmo_cnt     <= 4'd0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
            bytes_sent  <= 16'd0;
        end else begin
            state       <= state_d;
            uart_start  <= accept;
            done        <= byte_done;
            timeout_err <= tmo_fire;
            if (accept) begin
                uart_data  <= pick_byte;
                grant_id   <= pick_idx;
                last_grant <= pick_idx;
            end
            // Counts consecutive WAIT_BUSY cycles with the transmitter still idle.
            if (state == S_WAIT_BUSY && !uart_busy) begin
                tmo_cnt <= tmo_cnt + 4'd1;
            end else begin
                tmo_cnt <= 4'd0;
            end
            if (byte_done) begin
                bytes_sent <= bytes_sent + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: transaction-level model checked every cycle, plus directed scenarios
// with literal expectations (single request, round-robin, wrap/skip, busy timeout, busy in idle, reset mid-transfer).
module tb_uart_tx_arbiter;

    localparam int N        = 4;
    localparam int TMO      = 4;
    localparam int BUSY_LEN = 10;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [N-1:0]     req_valid = '0;
    logic [8*N-1:0]   req_data  = '0;
    logic [N-1:0]     req_ready;
    logic             uart_start;
    logic [7:0]       uart_data;
    logic             uart_busy = 1'b0;
    logic [1:0]       grant_id;
    logic             active;
    logic             done;
    logic             timeout_err;
    logic [15:0]      bytes_sent;

    int n_checks = 0;
    int n_err    = 0;

    uart_tx_arbiter #(
        .NUM_REQ      (N),
        .BUSY_TIMEOUT (TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .uart_start  (uart_start),
        .uart_data   (uart_data),
        .uart_busy   (uart_busy),
        .grant_id    (grant_id),
        .active      (active),
        .done        (done),
        .timeout_err (timeout_err),
        .bytes_sent  (bytes_sent)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transmitter model: sees start at an edge, then stays busy for BUSY_LEN cycles.
    bit   force_busy = 1'b0;
    bit   tx_ignore  = 1'b0;
    int   busy_left  = 0;
    logic start_seen = 1'b0;

    initial forever begin
        @(negedge clk);
        start_seen = uart_start;
        @(posedge clk);
        #2;
        if (rst) begin
            busy_left = 0;
            uart_busy = 1'b0;
        end else if (force_busy) begin
            uart_busy = 1'b1;
        end else begin
            if (busy_left > 0) busy_left--;
            if (start_seen && !tx_ignore) busy_left = BUSY_LEN;
            uart_busy = (busy_left > 0);
        end
    end

    // Reference model: one byte in flight, described by its age since acceptance.
    logic         m_in_flight;
    int           m_age;
    logic         m_seen;
    int           m_wait;
    int           m_ptr;
    int           m_grant;
    logic [7:0]   m_data;
    logic [15:0]  m_bytes;
    logic         m_done;
    logic         m_tmo;
    int           m_win;
    logic [N-1:0] m_ready;

    always @(negedge clk) begin
        if (rst) begin
            m_in_flight = 1'b0;
            m_age       = 0;
            m_seen      = 1'b0;
            m_wait      = 0;
            m_ptr       = N - 1;
            m_grant     = 0;
            m_data      = 8'h00;
            m_bytes     = 16'd0;
            m_done      = 1'b0;
            m_tmo       = 1'b0;
        end
        m_win   = -1;
        m_ready = '0;
        if (!rst && !m_in_flight && !uart_busy) begin
            for (int k = 1; k <= N; k++) begin
                if (m_win < 0 && req_valid[(m_ptr + k) % N]) m_win = (m_ptr + k) % N;
            end
        end
        if (m_win >= 0) m_ready[m_win] = 1'b1;

        check("req_ready",   32'(req_ready),   32'(m_ready));
        check("uart_start",  32'(uart_start),  32'(m_in_flight && m_age == 1));
        check("uart_data",   32'(uart_data),   32'(m_data));
        check("grant_id",    32'(grant_id),    32'(m_grant));
        check("active",      32'(active),      32'(m_in_flight));
        check("done",        32'(done),        32'(m_done));
        check("timeout_err", 32'(timeout_err), 32'(m_tmo));
        check("bytes_sent",  32'(bytes_sent),  32'(m_bytes));

        if (!rst) begin
            m_done = 1'b0;
            m_tmo  = 1'b0;
            if (!m_in_flight) begin
                if (m_win >= 0) begin
                    m_in_flight = 1'b1;
                    m_age       = 1;
                    m_seen      = 1'b0;
                    m_wait      = 0;
                    m_data      = req_data[8*m_win +: 8];
                    m_grant     = m_win;
                    m_ptr       = m_win;
                end
            end else begin
                if (m_age >= 2) begin
                    if (!m_seen) begin
                        if (uart_busy) begin
                            m_seen = 1'b1;
                        end else begin
                            m_wait++;
                            if (m_wait == TMO) begin
                                m_tmo       = 1'b1;
                                m_in_flight = 1'b0;
                            end
                        end
                    end else if (!uart_busy) begin
                        m_done      = 1'b1;
                        m_bytes     = m_bytes + 16'd1;
                        m_in_flight = 1'b0;
                    end
                end
                m_age++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns after the acceptance edge; cyc counts mid-cycle samples until req_ready was seen.
    task automatic wait_grant(output int id, output int cyc, output logic [N-1:0] rdy);
        bit got = 1'b0;
        id  = -1;
        cyc = 0;
        rdy = '0;
        while (!got && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (|req_ready) begin
                got = 1'b1;
                rdy = req_ready;
                for (int k = 0; k < N; k++) if (req_ready[k]) id = k;
            end
        end
        if (!got) check("grant_wait_expired", 32'd0, 32'd1);
        tick();
    endtask

    task automatic wait_pulse(input bit want_tmo, output int cyc);
        bit got = 1'b0;
        cyc = 0;
        while (!got && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (want_tmo ? timeout_err : done) got = 1'b1;
        end
        if (!got) check(want_tmo ? "timeout_wait_expired" : "done_wait_expired", 32'd0, 32'd1);
        tick();
    endtask

    task automatic pulse_reset();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int           id;
        int           cyc;
        logic [N-1:0] rdy;
        int           rr_id [6] = '{0, 1, 2, 3, 0, 1};
        logic [7:0]   rr_b  [6] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10, 8'h11};

        repeat (2) @(negedge clk);
        check("rst_ready",      32'(req_ready),  32'h0);
        check("rst_active",     32'(active),     32'h0);
        check("rst_uart_data",  32'(uart_data),  32'h00);
        check("rst_bytes_sent", 32'(bytes_sent), 32'h0);
        tick();
        rst = 1'b0;

        // Single request from requester 0.
        req_data[7:0] = 8'hA5;
        req_valid     = 4'b0001;
        wait_grant(id, cyc, rdy);
        check("single_ready", 32'(rdy), 32'h1);
        check("single_id",    32'(id),  32'd0);
        req_valid = '0;
        @(negedge clk);
        check("single_start", 32'(uart_start), 32'h1);
        check("single_data",  32'(uart_data),  32'hA5);
        wait_pulse(1'b0, cyc);
        check("single_bytes", 32'(bytes_sent), 32'd1);
        check("single_grant", 32'(grant_id),   32'd0);

        // Round-robin with all four requesters valid.
        pulse_reset();
        req_data  = {8'h13, 8'h12, 8'h11, 8'h10};
        req_valid = 4'b1111;
        for (int i = 0; i < 6; i++) begin
            wait_grant(id, cyc, rdy);
            check("rr_id", 32'(id), 32'(rr_id[i]));
            if (i == 5) req_valid = '0;
            @(negedge clk);
            check("rr_data", 32'(uart_data), 32'(rr_b[i]));
        end
        wait_pulse(1'b0, cyc);
        check("rr_bytes", 32'(bytes_sent), 32'd6);

        // Pointer wrap and skip: grant 2, then only 0 and 1 valid.
        req_valid = 4'b0100;
        wait_grant(id, cyc, rdy);
        check("wrap_first", 32'(id), 32'd2);
        req_valid = '0;
        wait_pulse(1'b0, cyc);
        req_valid = 4'b0011;
        wait_grant(id, cyc, rdy);
        check("wrap_to_0", 32'(id), 32'd0);
        wait_grant(id, cyc, rdy);
        check("wrap_to_1", 32'(id), 32'd1);
        req_valid = '0;
        wait_pulse(1'b0, cyc);

        // Transmitter ignores start: abort after the busy timeout.
        tx_ignore = 1'b1;
        req_valid = 4'b0001;
        wait_grant(id, cyc, rdy);
        check("tmo_id", 32'(id), 32'd0);
        req_valid = '0;
        wait_pulse(1'b1, cyc);
        check("tmo_latency", 32'(cyc),        32'd6);
        check("tmo_bytes",   32'(bytes_sent), 32'd9);
        check("tmo_idle",    32'(active),     32'd0);
        tx_ignore          = 1'b0;
        req_data[31:24]    = 8'h5C;
        req_valid          = 4'b1000;
        wait_grant(id, cyc, rdy);
        check("post_tmo_id", 32'(id), 32'd3);
        req_valid = '0;
        @(negedge clk);
        check("post_tmo_data", 32'(uart_data), 32'h5C);
        wait_pulse(1'b0, cyc);
        check("post_tmo_bytes", 32'(bytes_sent), 32'd10);

        // Busy held in IDLE blocks acceptance until it drops.
        force_busy = 1'b1;
        tick();
        req_data[15:8] = 8'h3E;
        req_valid      = 4'b0010;
        repeat (5) begin
            @(negedge clk);
            check("busy_idle_ready", 32'(req_ready), 32'h0);
        end
        tick();
        force_busy = 1'b0;
        wait_grant(id, cyc, rdy);
        check("busy_release_cyc", 32'(cyc), 32'd1);
        check("busy_release_id",  32'(id),  32'd1);
        req_valid = '0;
        wait_pulse(1'b0, cyc);
        check("busy_bytes", 32'(bytes_sent), 32'd11);

        // Reset asserted during WAIT_DONE.
        req_data[23:16] = 8'h77;
        req_valid       = 4'b0100;
        wait_grant(id, cyc, rdy);
        check("rstmid_id", 32'(id), 32'd2);
        req_valid = '0;
        repeat (5) tick();
        @(negedge clk);
        check("rstmid_busy_phase", 32'(active), 32'd1);
        tick();
        req_valid = 4'b1001;
        rst       = 1'b1;
        @(negedge clk);
        check("rstmid_start",  32'(uart_start),  32'h0);
        check("rstmid_data",   32'(uart_data),   32'h00);
        check("rstmid_grant",  32'(grant_id),    32'h0);
        check("rstmid_active", 32'(active),      32'h0);
        check("rstmid_done",   32'(done),        32'h0);
        check("rstmid_tmo",    32'(timeout_err), 32'h0);
        check("rstmid_bytes",  32'(bytes_sent),  32'h0);
        check("rstmid_ready",  32'(req_ready),   32'h0);
        tick();
        rst = 1'b0;
        wait_grant(id, cyc, rdy);
        check("post_rst_id", 32'(id), 32'd0);
        req_valid = 4'b1000;
        wait_grant(id, cyc, rdy);
        check("post_rst_next", 32'(id), 32'd3);
        req_valid = '0;
        wait_pulse(1'b0, cyc);
        check("post_rst_bytes", 32'(bytes_sent), 32'd2);

        repeat (3) tick();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
